byte_decode: RTL and testbench

Kyber ByteDecode_ELL unpacker for the Kyber-768-90s datapath. It converts a little-endian packed byte string into an array of ELL-bit polynomial coefficients. The block sits between byte-level buffers (public key, ciphertext, secret key) and the polynomial arithmetic units. It captures on a request strobe and presents registered coefficients one cycle later.

---
 rtl/byte_decode.sv | 53 +++++
 tb/tb_byte_decode.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_decode.sv
// Kyber ByteDecode_ELL unpacker: splits a little-endian byte string into ELL-bit
// coefficients, captured on in_valid and presented registered one cycle later.
module byte_decode #(
   parameter int unsigned ELL        = 12,
   parameter int unsigned NUM_COEFFS = 256,
   parameter int unsigned BYTE_COUNT = 32 * ELL / 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   input  logic [8*BYTE_COUNT-1:0]          byte_array,
   input  logic [$clog2(BYTE_COUNT):0]      len,
   output logic [ELL*NUM_COEFFS-1:0]        coeffs,
   output logic                             out_valid
);

   localparam int unsigned LEN_W   = $clog2(BYTE_COUNT) + 1;
   localparam int unsigned STR_W   = 8 * BYTE_COUNT;
   localparam int unsigned COEFF_W = ELL * NUM_COEFFS;

   logic [STR_W-1:0]   stream_c;
   logic [COEFF_W-1:0] coeffs_d, coeffs_q;
   logic               valid_q;

   // Zero bytes at or past len; len beyond BYTE_COUNT masks nothing, which is the clamp.
   always_comb begin
      stream_c = '0;
      for (int unsigned j = 0; j < BYTE_COUNT; j++) begin
         stream_c[j*8 +: 8] = (LEN_W'(j) < len) ? byte_array[j*8 +: 8] : 8'h00;
      end
   end

   // Coefficient i is stream[i*ELL +: ELL]; bits past the stream end zero-extend.
   always_comb begin
      coeffs_d = COEFF_W'(stream_c);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         coeffs_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            coeffs_q <= coeffs_d;
         end
      end
   end

   assign coeffs    = coeffs_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_byte_decode.sv
// Scoreboard bench for byte_decode: directed vectors plus randomized requests
// checked against a bit-level reference model of the ByteDecode rules.
module tb_byte_decode;

   localparam int unsigned ELL = 12;
   localparam int unsigned NC  = 256;
   localparam int unsigned BC  = 48;
   localparam int unsigned LW  = $clog2(BC) + 1;
   localparam int unsigned CW  = ELL * NC;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic [8*BC-1:0] byte_array;
   logic [LW-1:0]   len;
   logic [CW-1:0]   coeffs;
   logic            out_valid;

   logic            in_valid1;
   logic [255:0]    byte_array1;
   logic [5:0]      len1;
   logic [255:0]    coeffs1;
   logic            out_valid1;

   int checks = 0;
   int errors = 0;
   logic [CW-1:0] exp_q[$];
   logic [CW-1:0] mon_exp;

   always #5 clk = ~clk;

   byte_decode #(.ELL(ELL), .NUM_COEFFS(NC), .BYTE_COUNT(BC)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .byte_array(byte_array),
      .len(len), .coeffs(coeffs), .out_valid(out_valid));

   byte_decode #(.ELL(1), .NUM_COEFFS(256), .BYTE_COUNT(32)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .byte_array(byte_array1),
      .len(len1), .coeffs(coeffs1), .out_valid(out_valid1));

   // Reference: assemble each coefficient bit by bit from the masked byte stream.
   function automatic logic [CW-1:0] model(input logic [8*BC-1:0] b, input int l);
      logic [CW-1:0] r;
      int eff;
      eff = (l > int'(BC)) ? int'(BC) : l;
      r = '0;
      for (int i = 0; i < int'(NC); i++) begin
         int v;
         v = 0;
         for (int k = 0; k < int'(ELL); k++) begin
            int p;
            int by;
            p  = i * int'(ELL) + k;
            by = p / 8;
            if (by < eff && b[by*8 + (p % 8)]) v += (1 << k);
         end
         r[i*ELL +: ELL] = ELL'(v);
      end
      return r;
   endfunction

   // Monitor: every out_valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst && out_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid got 1 expected 0 (no request pending)");
         end else begin
            mon_exp = exp_q.pop_front();
            if (coeffs !== mon_exp) begin
               errors++;
               for (int i = 0; i < int'(NC); i++) begin
                  if (coeffs[i*ELL +: ELL] !== mon_exp[i*ELL +: ELL]) begin
                     $display("FAIL coeffs idx %0d got %0d expected %0d", i,
                              coeffs[i*ELL +: ELL], mon_exp[i*ELL +: ELL]);
                     break;
                  end
               end
            end
         end
      end
   end

   task automatic send(input logic [8*BC-1:0] b, input int l, input logic [CW-1:0] e);
      @(posedge clk);
      #1;
      in_valid   = 1'b1;
      byte_array = b;
      len        = LW'(l);
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         in_valid   = 1'b0;
         byte_array = {12{$urandom()}};
         len        = LW'($urandom_range(0, 63));
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout pending %0d expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got[63:0], want[63:0]);
      end
   endtask

   int tv[32] = '{'h49, 'h8B, 'h0B, 'hFF, 'hFE, 'hCE, 'hB3, 'hC5, 'h6C, 'hE7, 'h1E, 'h8B,
                  'hA4, 'h6F, 'h61, 'hEF, 'h07, 'hCD, 'h2A, 'hCD, 'h46, 'h16, 'h58, 'hBE,
                  'hCA, 'hAE, 'h59, 'hA2, 'h78, 'h50, 'hA1, 'hA4};
   int ref1[22] = '{2889, 184, 3839, 3311, 1459, 1740, 3815, 2225, 4004, 1558, 2031,
                    3280, 3370, 1132, 2070, 3045, 3786, 1434, 2210, 1287, 1185, 10};

   logic [8*BC-1:0] bytes_a, bytes_ff, rb;
   logic [CW-1:0]   e_full, e_len3, e_ff;

   initial begin
      rst = 1'b0;
      in_valid = 1'b0;  byte_array = '0;  len = '0;
      in_valid1 = 1'b0; byte_array1 = '0; len1 = '0;

      bytes_a = '0; bytes_ff = '1;
      e_full = '0; e_len3 = '0; e_ff = '0;
      for (int i = 0; i < 32; i++) bytes_a[i*8 +: 8] = 8'(tv[i]);
      for (int i = 0; i < 22; i++) e_full[i*ELL +: ELL] = ELL'(ref1[i]);
      e_len3[0 +: ELL]   = ELL'(2889);
      e_len3[ELL +: ELL] = ELL'(184);
      for (int i = 0; i < 32; i++) e_ff[i*ELL +: ELL] = ELL'(4095);

      repeat (3) @(negedge clk);
      check("reset_coeffs", coeffs, '0);
      check("reset_out_valid", CW'(out_valid), '0);
      @(posedge clk);
      #1 rst = 1'b1;

      // ELL = 1 instance: one bit per coefficient.
      @(posedge clk);
      #1;
      in_valid1 = 1'b1; byte_array1 = 256'hA5; len1 = 6'd32;
      @(posedge clk);
      #1 in_valid1 = 1'b0;
      @(negedge clk);
      check("ell1_out_valid", CW'(out_valid1), CW'(1'b1));
      check("ell1_coeffs", CW'(coeffs1), CW'(256'hA5));

      send(bytes_a, 48, e_full);
      idle(2);
      send(bytes_a, 3, e_len3);
      idle(1);
      send(bytes_a, 0, '0);
      send(bytes_a, 63, e_full);
      send(bytes_ff, 48, e_ff);
      send(bytes_a, 3, e_len3);
      idle(3);
      drain();

      // Reset landing between a request and its capture edge discards it.
      @(posedge clk);
      #1;
      in_valid = 1'b1; byte_array = bytes_ff; len = LW'(48);
      #2 rst = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("midreset_coeffs", coeffs, '0);
      check("midreset_out_valid", CW'(out_valid), '0);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("post_reset_coeffs", coeffs, '0);
      check("post_reset_out_valid", CW'(out_valid), '0);

      for (int n = 0; n < 60; n++) begin
         int l;
         for (int j = 0; j < int'(BC); j++) rb[j*8 +: 8] = 8'($urandom());
         if ($urandom_range(0, 5) == 0) rb = '1;
         l = int'($urandom_range(0, 63));
         send(rb, l, model(rb, l));
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(3);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
